// File: rtl/next_point_term_engine_if.sv
// Bus between the scanline controller and the term engine: configure/ack handshake in,
// per-element comparator terms and status out.
interface next_point_term_engine_if #(
  parameter int DW_INPUT        = 8,
  parameter int DW_INTEGER      = 16,
  parameter int DW_FRACTION     = 8,
  parameter int DW_OUT_FRACTION = 4,
  parameter int DW_STEP         = 4,
  parameter int NUM_ELEMENTS    = 64
);
  localparam int W  = DW_INTEGER + DW_FRACTION + 1;
  localparam int OW = W - DW_OUT_FRACTION;

  logic                              configure;
  logic [DW_INPUT-1:0]               r0;
  logic signed [W-1:0]               delta;
  logic [DW_STEP-1:0]                step;
  logic                              ack;
  logic                              final_scanpoint;
  logic [NUM_ELEMENTS-1:0][OW-1:0]   output_terms;
  logic                              ready;
  logic                              done_configuring;
  logic                              overflow;

  modport master (
    output configure, r0, delta, step, ack, final_scanpoint,
    input  output_terms, ready, done_configuring, overflow
  );

  modport slave (
    input  configure, r0, delta, step, ack, final_scanpoint,
    output output_terms, ready, done_configuring, overflow
  );
endinterface

// File: rtl/next_point_term_engine.sv
// Per-element comparator terms L_kn = 2k + 1 + B_n, filled LANES per side per cycle and
// advanced by 2*step per ack. Define NPT_TERM_SATURATE_EN to clamp instead of wrap on overflow.
module next_point_term_engine #(
  parameter int DW_INPUT        = 8,
  parameter int DW_INTEGER      = 16,
  parameter int DW_FRACTION     = 8,
  parameter int DW_OUT_FRACTION = 4,
  parameter int DW_STEP         = 4,
  parameter int NUM_ELEMENTS    = 64,
  parameter int LANES           = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  next_point_term_engine_if.slave bus
);
  localparam int W        = DW_INTEGER + DW_FRACTION + 1;
  localparam int F        = DW_FRACTION;
  localparam int H        = NUM_ELEMENTS / 2;
  localparam int FILL_CYC = H / LANES;
  localparam int CW       = (FILL_CYC > 1) ? $clog2(FILL_CYC) : 1;
  localparam int IW       = $clog2(NUM_ELEMENTS);
  localparam int LG_L     = $clog2(LANES);
  localparam int MAX_A    = (DW_INPUT + F + 7 > W) ? DW_INPUT + F + 7 : W;
  localparam int MAX_B    = (DW_STEP + F + 2 > MAX_A) ? DW_STEP + F + 2 : MAX_A;
  // Wide enough that no fill or advance result can wrap before the range check.
  localparam int WX       = MAX_B + $clog2(NUM_ELEMENTS) + 1;

  localparam logic signed [WX-1:0] WMAX = {{(WX-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [WX-1:0] WMIN = ~WMAX;

  function automatic logic out_of_range(input logic signed [WX-1:0] v);
    return (v > WMAX) || (v < WMIN);
  endfunction

  function automatic logic signed [W-1:0] fit(input logic signed [WX-1:0] v);
`ifdef NPT_TERM_SATURATE_EN
    if (v > WMAX) return WMAX[W-1:0];
    if (v < WMIN) return WMIN[W-1:0];
`endif
    return v[W-1:0];
  endfunction

  typedef enum logic [2:0] {IDLE, LOAD, FILL, WAIT, ADVANCE} state_t;

  state_t                 state_q, state_d;
  logic [DW_INPUT-1:0]    r0_q, r0_d;
  logic signed [W-1:0]    delta_q, delta_d;
  logic [DW_STEP-1:0]     step_q, step_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic signed [WX-1:0]   base_lo_q, base_lo_d, base_hi_q, base_hi_d;
  logic                   ready_q, ready_d, done_q, done_d, ovf_q, ovf_d;
  logic signed [W-1:0]    term_q [NUM_ELEMENTS];
  logic signed [W-1:0]    term_d [NUM_ELEMENTS];

  logic signed [WX-1:0]   delta_x, r0_x, b0, adv_x;
  logic signed [WX-1:0]   lane_off, lo_v, hi_v, sum_v;
  logic [IW-1:0]          lo_idx, hi_idx;
  int unsigned            base_idx;

  assign delta_x = {{(WX-W){delta_q[W-1]}}, delta_q};
  assign r0_x    = {{(WX-DW_INPUT){1'b0}}, r0_q};
  assign adv_x   = {{(WX-DW_STEP-1){1'b0}}, step_q, 1'b0} << F;
  // r0 * 32.46777 in shift-add form, plus the constant 1.0
  assign b0      = (WX'(1) << F) + (r0_x << (F + 5)) + (r0_x << (F - 1))
                 - (r0_x << (F - 5)) - (r0_x >> (10 - F));

  always_comb begin
    state_d   = state_q;
    r0_d      = r0_q;
    delta_d   = delta_q;
    step_d    = step_q;
    cnt_d     = cnt_q;
    base_lo_d = base_lo_q;
    base_hi_d = base_hi_q;
    ready_d   = ready_q;
    done_d    = done_q;
    ovf_d     = ovf_q;
    term_d    = term_q;
    lane_off  = '0;
    lo_v      = '0;
    hi_v      = '0;
    sum_v     = '0;
    lo_idx    = '0;
    hi_idx    = '0;
    base_idx  = 0;

    case (state_q)
      IDLE: begin
        if (bus.configure) begin
          r0_d    = bus.r0;
          delta_d = bus.delta;
          step_d  = bus.step;
          state_d = LOAD;
        end
      end
      LOAD: begin
        base_lo_d = b0;
        base_hi_d = b0 - delta_x;
        cnt_d     = '0;
        ovf_d     = 1'b0;
        state_d   = FILL;
      end
      FILL: begin
        // Lower half walks down from H-1 adding delta, upper half walks up from H subtracting it.
        base_idx = 32'(cnt_q) << LG_L;
        for (int unsigned l = 0; l < LANES; l++) begin
          lo_idx = IW'(H - 1 - base_idx - l);
          hi_idx = IW'(H + base_idx + l);
          lo_v   = base_lo_q + lane_off;
          hi_v   = base_hi_q - lane_off;
          term_d[lo_idx] = fit(lo_v);
          term_d[hi_idx] = fit(hi_v);
          ovf_d    = ovf_d | out_of_range(lo_v) | out_of_range(hi_v);
          lane_off = lane_off + delta_x;
        end
        base_lo_d = base_lo_q + (delta_x <<< LG_L);
        base_hi_d = base_hi_q - (delta_x <<< LG_L);
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == CW'(FILL_CYC - 1)) begin
          ready_d = 1'b1;
          done_d  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.ack) begin
          ready_d = 1'b0;
          state_d = bus.final_scanpoint ? IDLE : ADVANCE;
        end
      end
      ADVANCE: begin
        for (int unsigned e = 0; e < NUM_ELEMENTS; e++) begin
          sum_v = {{(WX-W){term_q[IW'(e)][W-1]}}, term_q[IW'(e)]} + adv_x;
          term_d[IW'(e)] = fit(sum_v);
          ovf_d = ovf_d | out_of_range(sum_v);
        end
        ready_d = 1'b1;
        state_d = WAIT;
      end
      default: state_d = IDLE;
    endcase

    // Entering or sitting in IDLE zeroes everything on the same edge.
    if (state_d == IDLE) begin
      r0_d      = '0;
      delta_d   = '0;
      step_d    = '0;
      cnt_d     = '0;
      base_lo_d = '0;
      base_hi_d = '0;
      ready_d   = 1'b0;
      done_d    = 1'b0;
      ovf_d     = 1'b0;
      term_d    = '{default: '0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      r0_q      <= '0;
      delta_q   <= '0;
      step_q    <= '0;
      cnt_q     <= '0;
      base_lo_q <= '0;
      base_hi_q <= '0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      term_q    <= '{default: '0};
    end else begin
      state_q   <= state_d;
      r0_q      <= r0_d;
      delta_q   <= delta_d;
      step_q    <= step_d;
      cnt_q     <= cnt_d;
      base_lo_q <= base_lo_d;
      base_hi_q <= base_hi_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      term_q    <= term_d;
    end
  end

  always_comb begin
    bus.output_terms = '0;
    for (int unsigned e = 0; e < NUM_ELEMENTS; e++)
      bus.output_terms[IW'(e)] = term_q[IW'(e)][W-1:DW_OUT_FRACTION];
  end

  assign bus.ready            = ready_q;
  assign bus.done_configuring = done_q;
  assign bus.overflow         = ovf_q;
endmodule
